can_bit_timing: RTL and testbench

- CAN bit-timing controller.
- Divides clk_i into time quanta (tq) and sequences each bit through SYNC_SEG, TSEG1 and TSEG2.
- Performs hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant edges of the bus.
- Emits the transmit-point and sample-point strobes that drive the CAN TX shifter and the RX bit sampler.

---
 rtl/can_bit_timing.sv | 154 +++++++++++++++
 tb/tb_can_bit_timing.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/can_bit_timing.sv
// CAN bit-timing controller: tq prescaler, SYNC/TSEG1/TSEG2 sequencer with hard sync
// and SJW-limited resync; emits registered tx-point and sample-point strobes.
module can_bit_timing #(
  parameter int BRP   = 5,
  parameter int TSEG1 = 13,
  parameter int TSEG2 = 6,
  parameter int SJW   = 2
) (
  input  logic       rst_i,
  input  logic       clk_i,
  input  logic       rx_i,
  input  logic       hard_sync_en_i,
  input  logic       resync_en_i,
  output logic       tx_point_o,
  output logic       sample_o,
  output logic       bit_o,
  output logic [1:0] seg_o
);

  if (BRP < 1 || BRP > 256) begin : g_bad_brp
    $error("can_bit_timing: BRP must be 1..256");
  end
  if (TSEG1 < 2 || TSEG1 > 16) begin : g_bad_tseg1
    $error("can_bit_timing: TSEG1 must be 2..16");
  end
  if (TSEG2 < 2 || TSEG2 > 8 || TSEG2 < SJW) begin : g_bad_tseg2
    $error("can_bit_timing: TSEG2 must be 2..8 and >= SJW");
  end
  if (SJW < 1 || SJW > 4) begin : g_bad_sjw
    $error("can_bit_timing: SJW must be 1..4");
  end

  typedef enum logic [1:0] {
    SEG_SYNC  = 2'd0,
    SEG_TSEG1 = 2'd1,
    SEG_TSEG2 = 2'd2
  } seg_t;

  localparam logic [7:0] PRESC_LAST = 8'(BRP - 1);
  localparam logic [4:0] T1 = 5'(TSEG1);
  localparam logic [4:0] T2 = 5'(TSEG2);
  localparam logic [4:0] SJ = 5'(SJW);

  seg_t       state;
  logic [7:0] presc_cnt;
  logic [4:0] tq_cnt;
  logic [2:0] ext;
  logic       sync_lock;
  logic       rx_m, rx_s, rx_d;

  logic       tick, edge_q, hard, resync, restart;
  logic [2:0] ext_nxt;
  logic [4:0] late_e, ext_w, tseg1_end, tseg2_end;

  // ext holds the TSEG1 lengthening in TSEG1 and the TSEG2 shortening in TSEG2;
  // phase error is always taken from the pre-tick state.
  always_comb begin
    tick    = (presc_cnt == PRESC_LAST);
    edge_q  = rx_d & ~rx_s & ~sync_lock & bit_o;
    hard    = edge_q & hard_sync_en_i;
    resync  = edge_q & ~hard_sync_en_i & resync_en_i;
    late_e  = tq_cnt + 5'd1;
    ext_nxt = ext;
    restart = hard;
    if (resync) begin
      if (state == SEG_TSEG1) begin
        ext_nxt = (late_e > SJ) ? SJ[2:0] : late_e[2:0];
      end else if (state == SEG_TSEG2) begin
        if ((T2 - tq_cnt) <= SJ) restart = 1'b1;
        else                     ext_nxt = SJ[2:0];
      end
    end
    ext_w     = {2'b00, ext_nxt};
    tseg1_end = T1 + ext_w - 5'd1;
    tseg2_end = T2 - ext_w - 5'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= SEG_SYNC;
      presc_cnt  <= 8'd0;
      tq_cnt     <= 5'd0;
      ext        <= 3'd0;
      sync_lock  <= 1'b0;
      tx_point_o <= 1'b0;
      sample_o   <= 1'b0;
      bit_o      <= 1'b1;
    end else begin
      tx_point_o <= 1'b0;
      sample_o   <= 1'b0;
      if (restart) begin
        state      <= SEG_SYNC;
        presc_cnt  <= 8'd0;
        tq_cnt     <= 5'd0;
        ext        <= 3'd0;
        sync_lock  <= 1'b1;
        tx_point_o <= 1'b1;
      end else begin
        ext       <= ext_nxt;
        presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
        if (resync) sync_lock <= 1'b1;
        if (tick) begin
          case (state)
            SEG_SYNC: begin
              state  <= SEG_TSEG1;
              tq_cnt <= 5'd0;
            end
            SEG_TSEG1: begin
              if (tq_cnt == tseg1_end) begin
                state     <= SEG_TSEG2;
                tq_cnt    <= 5'd0;
                ext       <= 3'd0;
                sample_o  <= 1'b1;
                bit_o     <= rx_s;
                sync_lock <= 1'b0;
              end else begin
                tq_cnt <= tq_cnt + 5'd1;
              end
            end
            SEG_TSEG2: begin
              if (tq_cnt == tseg2_end) begin
                state      <= SEG_SYNC;
                tq_cnt     <= 5'd0;
                ext        <= 3'd0;
                tx_point_o <= 1'b1;
              end else begin
                tq_cnt <= tq_cnt + 5'd1;
              end
            end
            default: begin
              state  <= SEG_SYNC;
              tq_cnt <= 5'd0;
            end
          endcase
        end
      end
    end
  end

  assign seg_o = state;

endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing (default parameters: 5 clk/tq, 20 tq/bit).
module tb_can_bit_timing;

  logic       rst_i, clk_i, rx_i, hard_sync_en_i, resync_en_i;
  logic       tx_point_o, sample_o, bit_o;
  logic [1:0] seg_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  can_bit_timing dut (
    .rst_i          (rst_i),
    .clk_i          (clk_i),
    .rx_i           (rx_i),
    .hard_sync_en_i (hard_sync_en_i),
    .resync_en_i    (resync_en_i),
    .tx_point_o     (tx_point_o),
    .sample_o       (sample_o),
    .bit_o          (bit_o),
    .seg_o          (seg_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  // sel 0 = tx_point_o, 1 = sample_o; returns cyc of the pulse or -1 on timeout
  task automatic wait_evt(input int sel, output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if ((sel == 0 && tx_point_o) || (sel == 1 && sample_o)) begin
        c = cyc;
        break;
      end
    end
  endtask

  // reset, release, and return the cyc of the first tx_point after release
  task automatic start_bit(input string tag, output int t);
    int r;
    rst_i = 1'b0; rx_i = 1'b1; hard_sync_en_i = 1'b0; resync_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    r = cyc;
    wait_evt(0, t);
    chk(tag, t, r + 100);
  endtask

  int r, t, c, pulses;

  initial begin
    rst_i = 1'b0; rx_i = 1'b1; hard_sync_en_i = 1'b0; resync_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_tx", tx_point_o, 0);
    chk("rst_sample", sample_o, 0);
    chk("rst_bit", bit_o, 1);
    chk("rst_seg", seg_o, 0);

    // free run
    rst_i = 1'b1;
    r = cyc;
    wait_evt(1, c);
    chk("free_first_sample", c, r + 70);
    chk("free_seg2", seg_o, 2);
    wait_evt(0, t);
    chk("free_first_tx", t, r + 100);
    @(negedge clk_i);
    chk("free_tx_width", tx_point_o, 0);
    wait_until(t + 10);
    chk("free_seg1", seg_o, 1);
    wait_evt(1, c);
    chk("free_sample", c, t + 70);
    chk("free_bit", bit_o, 1);
    wait_evt(0, c);
    chk("free_period", c, t + 100);

    // hard sync in TSEG2
    start_bit("hs_t0", t);
    hard_sync_en_i = 1'b1;
    wait_until(t + 80);
    chk("hs_pre_seg", seg_o, 2);
    rx_i = 1'b0;
    wait_evt(0, c);
    chk("hs_tx", c, t + 83);
    chk("hs_tx_seg", seg_o, 0);
    wait_evt(1, c);
    chk("hs_sample", c, t + 153);
    chk("hs_bit", bit_o, 0);

    // late edge at TSEG1 tq 0
    start_bit("le0_t0", t);
    resync_en_i = 1'b1;
    wait_until(t + 5);
    rx_i = 1'b0;
    wait_evt(1, c);
    chk("le0_sample", c, t + 75);
    chk("le0_bit", bit_o, 0);
    wait_evt(0, c);
    chk("le0_next_tx", c, t + 105);

    // late edge at TSEG1 tq 5, capped at SJW
    start_bit("le5_t0", t);
    resync_en_i = 1'b1;
    wait_until(t + 30);
    rx_i = 1'b0;
    wait_evt(1, c);
    chk("le5_sample", c, t + 80);

    // early edge, 1 tq remaining
    start_bit("ee1_t0", t);
    resync_en_i = 1'b1;
    wait_until(t + 94);
    rx_i = 1'b0;
    wait_evt(0, c);
    chk("ee1_tx", c, t + 97);
    wait_evt(1, c);
    chk("ee1_sample", c, t + 167);
    chk("ee1_bit", bit_o, 0);

    // early edge, 5 tq remaining
    start_bit("ee5_t0", t);
    resync_en_i = 1'b1;
    wait_until(t + 74);
    rx_i = 1'b0;
    wait_evt(0, c);
    chk("ee5_bitlen", c, t + 90);

    // two edges in one bit: second is locked out
    start_bit("lock_t0", t);
    resync_en_i = 1'b1;
    wait_until(t + 5);
    rx_i = 1'b0;
    wait_until(t + 20);
    rx_i = 1'b1;
    wait_until(t + 40);
    rx_i = 1'b0;
    wait_evt(1, c);
    chk("lock_sample", c, t + 75);

    // enables low, then edge after dominant sample
    start_bit("dom_t0", t);
    wait_until(t + 20);
    rx_i = 1'b0;
    wait_evt(1, c);
    chk("noen_sample", c, t + 70);
    chk("noen_bit", bit_o, 0);
    wait_until(t + 80);
    rx_i = 1'b1;
    wait_evt(0, c);
    chk("dom_tx", c, t + 100);
    resync_en_i = 1'b1;
    wait_until(t + 105);
    rx_i = 1'b0;
    wait_evt(1, c);
    chk("dom_sample", c, t + 170);

    // both enables: hard sync wins
    start_bit("both_t0", t);
    hard_sync_en_i = 1'b1;
    resync_en_i = 1'b1;
    wait_until(t + 5);
    rx_i = 1'b0;
    wait_evt(0, c);
    chk("both_tx", c, t + 8);
    wait_evt(1, c);
    chk("both_sample", c, t + 78);

    // reset mid-TSEG1
    start_bit("mrst_t0", t);
    wait_until(t + 20);
    rst_i = 1'b0;
    #1;
    chk("mrst_seg", seg_o, 0);
    chk("mrst_tx", tx_point_o, 0);
    chk("mrst_sample", sample_o, 0);
    chk("mrst_bit", bit_o, 1);
    pulses = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (tx_point_o || sample_o || seg_o != 2'd0) pulses++;
    end
    chk("mrst_quiet", pulses, 0);
    rst_i = 1'b1;
    r = cyc;
    wait_evt(1, c);
    chk("mrst_sample_after", c, r + 70);
    wait_evt(0, c);
    chk("mrst_tx_after", c, r + 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
